load_store_unit: RTL and testbench

- Memory-access stage downstream of the instruction decoder.
- Accepts one load or store request per transaction: byte address, funct3 size/sign code, store data.
- Performs the word-aligned access on the 32-bit system bus, using read-modify-write for sub-word stores.
- Returns a sign- or zero-extended load result, a done pulse, and an error flag for misaligned, illegal or timed-out accesses.

---
 rtl/load_store_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage behind the decoder. Issues one
// word-aligned access on the 32-bit system bus for each accepted load or store.
// SB/SH are done as read-modify-write. Returns an extended load result with a
// done pulse. Misaligned or illegal requests and bus timeouts complete with error=1.
// All outputs come from flops, so done/error/loadData appear the cycle after
// the DONE state. A new request is accepted from the cycle after that pulse.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  input  logic        reqWrite,
  input  logic [2:0]  reqFunct3,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqData,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] loadData,
  output logic        busRequest,
  output logic        busWriteEnable,
  output logic [31:0] busAddress,
  output logic [31:0] busDataOut,
  input  logic [31:0] busDataIn,
  input  logic        busReady
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_MODIFY = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int unsigned   CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  logic [2:0]    state_q, state_d;
  logic          write_q, write_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    lane_q, lane_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [31:0]   load_data_q, load_data_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_dout_q, bus_dout_d;

  logic          req_bad;
  logic [CW-1:0] cnt_inc;
  logic          timed_out;

  // Select the addressed lane of a bus word and extend it to 32 bits.
  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] lane,
                                         input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  // Overwrite the addressed byte or half of a word with the store data.
  function automatic logic [31:0] merge(input logic [2:0] f3, input logic [1:0] lane,
                                        input logic [31:0] word, input logic [31:0] d);
    logic [31:0] m;
    m = word;
    if (f3[0]) begin
      if (lane[1]) m[31:16] = d[15:0];
      else         m[15:0]  = d[15:0];
    end else begin
      case (lane)
        2'd0:    m[7:0]   = d[7:0];
        2'd1:    m[15:8]  = d[7:0];
        2'd2:    m[23:16] = d[7:0];
        default: m[31:24] = d[7:0];
      endcase
    end
    return m;
  endfunction

  // Legality and alignment check of the incoming request.
  always_comb begin
    if (reqWrite) req_bad = reqFunct3[2] || (reqFunct3[1:0] == 2'b11);
    else          req_bad = (reqFunct3[1:0] == 2'b11) || (reqFunct3 == 3'b110);
    if (reqFunct3[1:0] == 2'b01 && reqAddress[0])          req_bad = 1'b1;
    if (reqFunct3[1:0] == 2'b10 && reqAddress[1:0] != 2'b00) req_bad = 1'b1;
  end

  // Next-state and output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    done_d      = 1'b0;
    error_d     = error_q;
    load_data_d = load_data_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_dout_d  = bus_dout_q;
    cnt_inc     = cnt_q + CW'(1);
    timed_out   = (TIMEOUT != 0) && !busReady && (cnt_inc == TO_MAX);

    case (state_q)
      S_IDLE: begin
        // done_q still high means this is the completion cycle; hold off one cycle.
        if (reqValid && !done_q) begin
          write_d  = reqWrite;
          funct3_d = reqFunct3;
          lane_d   = reqAddress[1:0];
          wdata_d  = reqData;
          cnt_d    = '0;
          if (req_bad) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d      = 1'b0;
            bus_req_d  = 1'b1;
            bus_addr_d = {reqAddress[31:2], 2'b00};
            if (reqWrite && reqFunct3 == 3'b010) begin
              bus_we_d   = 1'b1;
              bus_dout_d = reqData;
              state_d    = S_WRITE;
            end else begin
              bus_we_d = 1'b0;
              state_d  = S_READ;
            end
          end
        end
      end
      S_READ: begin
        if (busReady) begin
          rdata_d   = busDataIn;
          bus_req_d = 1'b0;
          state_d   = write_q ? S_MODIFY : S_DONE;
        end else if (timed_out) begin
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_MODIFY: begin
        bus_dout_d = merge(funct3_q, lane_q, rdata_q, wdata_q);
        bus_req_d  = 1'b1;
        bus_we_d   = 1'b1;
        cnt_d      = '0;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (busReady) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          state_d   = S_DONE;
        end else if (timed_out) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        error_d = err_q;
        if (!write_q && !err_q) load_data_d = extend(funct3_q, lane_q, rdata_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      funct3_q    <= '0;
      lane_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      load_data_q <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      done_q      <= done_d;
      error_q     <= error_d;
      load_data_q <= load_data_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_dout_q  <= bus_dout_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign error          = error_q;
  assign loadData       = load_data_q;
  assign busRequest     = bus_req_q;
  assign busWriteEnable = bus_we_q;
  assign busAddress     = bus_addr_q;
  assign busDataOut     = bus_dout_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: drives load/store transactions against a byte-array
// memory model. For each accepted request the bench builds a per-cycle picture
// of the expected outputs from the latency rules. A negedge process compares
// the DUT against that picture every cycle.
module tb_load_store_unit;
  localparam int unsigned TO = 4;
  localparam int N = 8192;

  logic        clk = 1'b0;
  logic        reset, reqValid, reqWrite;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddress, reqData;
  logic        busy, done, error;
  logic [31:0] loadData;
  logic        busRequest, busWriteEnable;
  logic [31:0] busAddress, busDataOut, busDataIn;
  logic        busReady;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqWrite(reqWrite),
    .reqFunct3(reqFunct3), .reqAddress(reqAddress), .reqData(reqData),
    .busy(busy), .done(done), .error(error), .loadData(loadData),
    .busRequest(busRequest), .busWriteEnable(busWriteEnable),
    .busAddress(busAddress), .busDataOut(busDataOut),
    .busDataIn(busDataIn), .busReady(busReady)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Expected picture per cycle, plus the bus responder's schedule.
  logic        e_req [N], e_we [N], e_done [N], e_err [N], e_ldchk [N], e_busy [N], rdy [N];
  logic [31:0] e_addr [N], e_dout [N], e_ld [N], rdata [N];
  logic [7:0]  mem [64];  // bytes at 0x100..0x13F
  logic        last_err;
  logic [31:0] last_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit is_legal(input bit wr, input logic [2:0] f3);
    if (wr) return f3 inside {3'd0, 3'd1, 3'd2};
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off);
    longint v;
    int n;
    v = 0;
    n = nbytes(f3);
    for (int i = 0; i < n; i++) v += longint'(mem[off + i]) << (8 * i);
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3, input int off, input logic [31:0] d);
    logic [7:0] b [4];
    int base;
    base = off & ~3;
    for (int i = 0; i < 4; i++) b[i] = mem[base + i];
    for (int i = 0; i < nbytes(f3); i++) b[(off - base) + i] = d[8*i +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic commit_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
    int off;
    off = int'(addr - 32'h100);
    for (int i = 0; i < nbytes(f3); i++) mem[off + i] = d[8*i +: 8];
  endtask

  task automatic set_word(input int off, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[off + i] = w[8*i +: 8];
  endtask

  task automatic clear_exp(input int c);
    e_req[c] = 0; e_busy[c] = 0; e_done[c] = 0; rdy[c] = 0;
  endtask

  // One bus phase beginning in cycle c; w wait cycles before busReady.
  task automatic sched_phase(input int c, input bit we, input logic [31:0] wa,
                             input logic [31:0] dout, input logic [31:0] rd, input int w,
                             output int len, output bit tmo);
    tmo = (TO != 0) && (w >= int'(TO));
    len = tmo ? int'(TO) : w + 1;
    for (int i = 0; i < len; i++) begin
      e_req[c+i] = 1; e_we[c+i] = we; e_addr[c+i] = wa; e_dout[c+i] = dout;
      rdy[c+i] = (!tmo && i == len - 1);
      if (!we && !tmo && i == len - 1) rdata[c+i] = rd;
    end
  endtask

  // Whole transaction accepted in cycle t; returns its done cycle.
  task automatic sched_txn(input int t, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] d, input int w1, input int w2,
                           output int dc, output logic [31:0] val, output bit commit);
    int off, n, c, len, len2;
    bit tmo, err;
    logic [31:0] wa, word;
    off = int'(addr - 32'h100);
    wa = {addr[31:2], 2'b00};
    n = nbytes(f3);
    err = !is_legal(wr, f3) || (off % n != 0);
    commit = 0; val = 0; c = t + 1; dc = t + 2;
    word = model_load(3'b010, off & ~3);
    if (err) begin
      dc = t + 2;
    end else if (wr && n == 4) begin
      val = d;
      sched_phase(c, 1, wa, d, 0, w1, len, tmo);
      err = tmo; commit = !tmo; dc = c + len + 1;
    end else if (!wr) begin
      val = model_load(f3, off);
      sched_phase(c, 0, wa, 0, word, w1, len, tmo);
      err = tmo; dc = c + len + 1;
    end else begin
      val = model_store(f3, off, d);
      sched_phase(c, 0, wa, 0, word, w1, len, tmo);
      if (tmo) begin
        err = 1; dc = c + len + 1;
      end else begin
        sched_phase(c + len + 1, 1, wa, val, 0, w2, len2, tmo);
        err = tmo; commit = !tmo; dc = c + len + 1 + len2 + 1;
      end
    end
    for (int i = t + 1; i < dc; i++) e_busy[i] = 1;
    e_done[dc] = 1; e_err[dc] = err; e_ldchk[dc] = !wr && !err; e_ld[dc] = val;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request now, run to the cycle after done; junk requests while busy.
  task automatic run_txn(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] d, input int w1, input int w2, input bit junk,
                         output int lat, output logic [31:0] val);
    int t, dc;
    bit commit;
    t = cyc;
    sched_txn(t, wr, f3, addr, d, w1, w2, dc, val, commit);
    reqValid = 1; reqWrite = wr; reqFunct3 = f3; reqAddress = addr; reqData = d;
    while (cyc < dc) begin
      step();
      if (junk && $urandom_range(1, 0) == 1) begin
        reqValid = 1; reqWrite = 1'($urandom); reqFunct3 = 3'($urandom);
        reqAddress = $urandom; reqData = $urandom;
      end else begin
        reqValid = 0;
      end
    end
    step();
    reqValid = 0;
    if (commit) commit_store(f3, addr, d);
    lat = dc - t;
  endtask

  // Bus responder: busReady/busDataIn follow the schedule; junk elsewhere.
  initial begin
    busReady = 0; busDataIn = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (cyc < N) begin
        busReady = rdy[cyc]; busDataIn = rdata[cyc];
      end
    end
  end

  // Per-cycle comparison of every output against the expected picture.
  always @(negedge clk) begin
    if (chk_en && cyc < N) begin
      check("busy", {31'b0, busy}, {31'b0, e_busy[cyc]});
      check("done", {31'b0, done}, {31'b0, e_done[cyc]});
      check("busRequest", {31'b0, busRequest}, {31'b0, e_req[cyc]});
      if (e_req[cyc]) begin
        check("busWriteEnable", {31'b0, busWriteEnable}, {31'b0, e_we[cyc]});
        check("busAddress", busAddress, e_addr[cyc]);
        if (e_we[cyc]) check("busDataOut", busDataOut, e_dout[cyc]);
      end
      if (e_done[cyc]) begin
        check("error", {31'b0, error}, {31'b0, e_err[cyc]});
        if (e_ldchk[cyc]) check("loadData", loadData, e_ld[cyc]);
      end
      if (busRequest && busWriteEnable && busReady) last_wr = busDataOut;
      if (done) last_err = error;
    end
  end

  initial begin
    #80000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected end", cyc);
    $fatal(1);
  end

  initial begin
    int lat, t, dc;
    logic [31:0] v;
    bit commit;
    bit         e_wr  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0] e_f3  [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
    logic [31:0] e_ad [4] = '{32'h101, 32'h102, 32'h100, 32'h100};

    for (int i = 0; i < N; i++) begin
      e_req[i] = 0; e_we[i] = 0; e_done[i] = 0; e_err[i] = 0; e_ldchk[i] = 0; e_busy[i] = 0;
      e_addr[i] = 0; e_dout[i] = 0; e_ld[i] = 0;
      rdy[i] = 1'($urandom); rdata[i] = $urandom;
    end
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    set_word(0, 32'h8899AABB);
    last_err = 0; last_wr = 0;

    reset = 1; reqValid = 0; reqWrite = 0; reqFunct3 = 0; reqAddress = 0; reqData = 0;
    step();
    chk_en = 1;
    step();
    check("reset_loadData", loadData, 32'h0);
    check("reset_busAddress", busAddress, 32'h0);
    check("reset_busDataOut", busDataOut, 32'h0);
    check("reset_error", {31'b0, error}, 32'h0);
    check("reset_busWriteEnable", {31'b0, busWriteEnable}, 32'h0);
    reset = 0;
    step();

    // Loads from word 0x100 = 0x8899AABB, zero-wait bus.
    run_txn(0, 3'b000, 32'h101, 0, 0, 0, 0, lat, v);
    check("lb_model", v, 32'hFFFFFFAA); check("lb_loadData", loadData, 32'hFFFFFFAA); check("lb_lat", 32'(lat), 3);
    run_txn(0, 3'b100, 32'h103, 0, 0, 0, 0, lat, v);
    check("lbu_loadData", loadData, 32'h00000088);
    run_txn(0, 3'b001, 32'h102, 0, 0, 0, 0, lat, v);
    check("lh_loadData", loadData, 32'hFFFF8899);
    run_txn(0, 3'b010, 32'h100, 0, 0, 0, 0, lat, v);
    check("lw_loadData", loadData, 32'h8899AABB); check("lw_lat", 32'(lat), 3);

    // Sub-word stores via read-modify-write.
    last_wr = 0;
    run_txn(1, 3'b000, 32'h102, 32'h123456CC, 0, 0, 0, lat, v);
    check("sb_write", last_wr, 32'h88CCAABB); check("sb_lat", 32'(lat), 5);
    set_word(0, 32'h8899AABB);
    last_wr = 0;
    run_txn(1, 3'b001, 32'h100, 32'h00001122, 0, 0, 0, lat, v);
    check("sh_write", last_wr, 32'h88991122);
    last_wr = 0;
    run_txn(1, 3'b010, 32'h108, 32'hDEADBEEF, 0, 0, 0, lat, v);
    check("sw_write", last_wr, 32'hDEADBEEF); check("sw_lat", 32'(lat), 3);

    // Misaligned and illegal requests: error, no bus activity.
    for (int i = 0; i < 4; i++) begin
      last_err = 0;
      run_txn(e_wr[i], e_f3[i], e_ad[i], 32'h5A5A5A5A, 0, 0, 0, lat, v);
      check("err_flag", {31'b0, last_err}, 32'h1); check("err_lat", 32'(lat), 2);
    end

    // Three wait states, junk requests while busy.
    run_txn(0, 3'b010, 32'h100, 0, 3, 0, 1, lat, v);
    check("lw_wait_loadData", loadData, 32'h88991122); check("lw_wait_lat", 32'(lat), 6);

    // Timeouts: busReady never returned.
    last_err = 0;
    run_txn(0, 3'b010, 32'h104, 0, 10, 0, 0, lat, v);
    check("lw_timeout_err", {31'b0, last_err}, 32'h1); check("lw_timeout_lat", 32'(lat), 6);
    last_err = 0;
    run_txn(1, 3'b000, 32'h105, 32'h55, 10, 0, 0, lat, v);
    check("sb_timeout_err", {31'b0, last_err}, 32'h1);

    // Randomized traffic.
    for (int k = 0; k < 200; k++) begin
      bit wr;
      logic [2:0] f3;
      wr = 1'($urandom);
      if ($urandom_range(7, 0) == 0) f3 = 3'($urandom);
      else if (wr) f3 = 3'($urandom_range(2, 0));
      else begin
        f3 = 3'($urandom_range(4, 0));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      run_txn(wr, f3, 32'h100 + 32'($urandom_range(63, 0)), $urandom,
              $urandom_range(5, 0), $urandom_range(5, 0), 1'($urandom), lat, v);
      for (int g = $urandom_range(2, 0); g > 0; g--) step();
    end

    // Reset while an SB sits in MODIFY: abort without write or done.
    t = cyc;
    sched_txn(t, 1, 3'b000, 32'h105, 32'h77, 0, 0, dc, v, commit);
    reqValid = 1; reqWrite = 1; reqFunct3 = 3'b000; reqAddress = 32'h105; reqData = 32'h77;
    step();
    reqValid = 0;
    step();
    reset = 1;
    for (int i = t + 3; i < t + 12; i++) clear_exp(i);
    step();
    reset = 0;
    check("abort_loadData", loadData, 32'h0);
    step();
    run_txn(0, 3'b010, 32'h104, 0, 0, 0, 0, lat, v);
    check("after_abort_lat", 32'(lat), 3);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
